// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master: fetches a block of words from fixed-latency on-chip memory
// and streams it out through a first-word-fall-through FIFO.
module onchip_mem_stream_reader #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_chipselect,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, remain_q, remain_d;
  logic                discard_q, discard_d;
  logic [READ_LATENCY:1] vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d, inflight, occ;
  logic                accept, push, pop, flush;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= READ_LATENCY; i++) inflight = inflight + CW'(vld_pipe_q[i]);
  end

  // Reserving FIFO space for in-flight reads is what makes overflow impossible.
  assign occ            = cnt_q + inflight;
  assign avm_read       = (state_q == S_RUN) && (remain_q != '0) && (occ < DEPTH_C);
  assign avm_chipselect = avm_read;
  assign avm_byteenable = 4'hF;
  assign avm_address    = addr_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_FINISH);

  assign accept   = avm_read && !avm_waitrequest;
  assign flush    = abort && (state_q != S_IDLE);
  assign push     = vld_pipe_q[READ_LATENCY] && !discard_q && !flush;
  assign st_valid = (cnt_q != '0);
  assign st_data  = st_valid ? mem_q[rd_ptr_q] : '0;
  assign pop      = st_valid && st_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    discard_d  = discard_q;
    vld_pipe_d = '0;
    vld_pipe_d[1] = accept;
    for (int i = 2; i <= READ_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    if (accept) begin
      addr_d   = addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
    end
    case (state_q)
      S_IDLE: if (start) begin
        addr_d    = base_addr;
        remain_d  = word_count;
        discard_d = 1'b0;
        state_d   = (word_count != '0) ? S_RUN : S_FINISH;
      end
      S_RUN:    if (flush || (accept && remain_q == ADDR_W'(1))) state_d = S_DRAIN;
      S_DRAIN:  if (inflight == '0 && cnt_q == '0) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Returns still in the pipe after an abort must never reach the stream.
    if (flush) discard_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      discard_q  <= 1'b0;
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      discard_q  <= discard_d;
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= avm_readdata;
  end
endmodule
